full_subtractor: RTL and testbench

//  - Full subtractor: computes a - b - Bin per bit, with borrow rippling LSB to MSB.
//  - Provides combinational difference/borrow outputs plus a registered copy of both.
//  - Counts borrow-out events for datapath debug.
//  - Used as the leaf subtract cell and the narrow-word subtractor in the arithmetic datapath.

---
 rtl/full_subtractor.sv | 85 ++++++++
 tb/tb_full_subtractor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor {Bout,D} = a - b - Bin with a registered copy and a saturating borrow counter.
// Optional registered signed-overflow flag ovf_q is built only when FS_OVF_EN is defined.
module full_subtractor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic [WIDTH-1:0] D_q,
    output logic             Bout_q,
`ifdef FS_OVF_EN
    output logic [CNT_W-1:0] borrow_cnt,
    output logic             ovf_q
`else
    output logic [CNT_W-1:0] borrow_cnt
`endif
);

    logic [WIDTH:0]   w_bw;
    logic [WIDTH-1:0] w_diff;

    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic [CNT_W-1:0] r_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    assign w_bw[0] = Bin;

    // Borrow ripples from the LSB cell upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_diff[i]  = a[i] ^ b[i] ^ w_bw[i];
        assign w_bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_bw[i]);
    end

    assign D    = w_diff;
    assign Bout = w_bw[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d    <= '0;
            r_bout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_d    <= w_diff;
            r_bout <= w_bw[WIDTH];
            if (w_bw[WIDTH]) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end
    end

    assign D_q        = r_d;
    assign Bout_q     = r_bout;
    assign borrow_cnt = r_cnt;

`ifdef FS_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Operands of differing sign whose result sign departs from the minuend overflowed.
    assign w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf_q = r_ovf;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor: 1-bit, 4-bit and narrow-counter instances share clock and reset.
module tb_full_subtractor;

    logic clk;
    logic rst;

    logic       a1, b1, bin1;
    logic       d1, bout1, dq1, boutq1;
    logic [7:0] cnt1;

    logic [3:0] a4, b4;
    logic       bin4;
    logic [3:0] d4, dq4;
    logic       bout4, boutq4;
    logic [7:0] cnt4;

    logic       a2, b2, bin2;
    logic       d2, bout2, dq2, boutq2;
    logic [1:0] cnt2;

`ifdef FS_OVF_EN
    logic ovf1, ovf4, ovf2;
`endif

    int checks;
    int errors;

    full_subtractor #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .Bin(bin1),
        .D(d1), .Bout(bout1), .D_q(dq1), .Bout_q(boutq1),
`ifdef FS_OVF_EN
        .borrow_cnt(cnt1), .ovf_q(ovf1)
`else
        .borrow_cnt(cnt1)
`endif
    );

    full_subtractor #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .Bin(bin4),
        .D(d4), .Bout(bout4), .D_q(dq4), .Bout_q(boutq4),
`ifdef FS_OVF_EN
        .borrow_cnt(cnt4), .ovf_q(ovf4)
`else
        .borrow_cnt(cnt4)
`endif
    );

    full_subtractor #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .a(a2), .b(b2), .Bin(bin2),
        .D(d2), .Bout(bout2), .D_q(dq2), .Bout_q(boutq2),
`ifdef FS_OVF_EN
        .borrow_cnt(cnt2), .ovf_q(ovf2)
`else
        .borrow_cnt(cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (dq4 !== 4'h0) begin errors++; $display("FAIL reset_dq4: got %h expected %h", dq4, 4'h0); end
        checks++;
        if (boutq4 !== 1'b0) begin errors++; $display("FAIL reset_boutq4: got %b expected %b", boutq4, 1'b0); end
        checks++;
        if (cnt4 !== 8'd0) begin errors++; $display("FAIL reset_cnt4: got %0d expected %0d", cnt4, 0); end
        checks++;
        if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2: got %0d expected %0d", cnt2, 0); end
`ifdef FS_OVF_EN
        checks++;
        if (ovf4 !== 1'b0) begin errors++; $display("FAIL reset_ovf4: got %b expected %b", ovf4, 1'b0); end
`endif
        bin1 = 1'b1;
        #1;
        checks++;
        if ({d1, bout1} !== 2'b11) begin errors++; $display("FAIL reset_comb1: got %b expected %b", {d1, bout1}, 2'b11); end
        bin1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [1:0] exp_tab [8];
        logic [2:0] v;
        exp_tab = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, bin1} = v;
            #1;
            checks++;
            if ({d1, bout1} !== exp_tab[i]) begin
                errors++;
                $display("FAIL sweep_%0d: got %b expected %b", i, {d1, bout1}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_no_borrow();
        logic [7:0] cnt_before;
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; bin1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({dq1, boutq1} !== 2'b11) begin errors++; $display("FAIL prime_q1: got %b expected %b", {dq1, boutq1}, 2'b11); end
        cnt_before = cnt1;
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b1;
        #1;
        checks++;
        if ({d1, bout1} !== 2'b00) begin errors++; $display("FAIL nb_comb: got %b expected %b", {d1, bout1}, 2'b00); end
        @(negedge clk);
        checks++;
        if ({dq1, boutq1} !== 2'b00) begin errors++; $display("FAIL nb_q: got %b expected %b", {dq1, boutq1}, 2'b00); end
        checks++;
        if (cnt1 !== cnt_before) begin errors++; $display("FAIL nb_cnt: got %0d expected %0d", cnt1, cnt_before); end
    endtask

    task automatic test_width4();
        @(negedge clk);
        checks++;
        if (cnt4 !== 8'd0) begin errors++; $display("FAIL w4_cnt_start: got %0d expected %0d", cnt4, 0); end
        a4 = 4'h3; b4 = 4'h5; bin4 = 1'b1;
        #1;
        checks++;
        if (d4 !== 4'hD) begin errors++; $display("FAIL w4_d: got %h expected %h", d4, 4'hD); end
        checks++;
        if (bout4 !== 1'b1) begin errors++; $display("FAIL w4_bout: got %b expected %b", bout4, 1'b1); end
        @(negedge clk);
        checks++;
        if (dq4 !== 4'hD) begin errors++; $display("FAIL w4_dq: got %h expected %h", dq4, 4'hD); end
        checks++;
        if (boutq4 !== 1'b1) begin errors++; $display("FAIL w4_boutq: got %b expected %b", boutq4, 1'b1); end
        checks++;
        if (cnt4 !== 8'd1) begin errors++; $display("FAIL w4_cnt: got %0d expected %0d", cnt4, 1); end
        a4 = 4'hA; b4 = 4'h3; bin4 = 1'b0;
        #1;
        checks++;
        if ({bout4, d4} !== 5'h07) begin errors++; $display("FAIL w4_nb: got %h expected %h", {bout4, d4}, 5'h07); end
        @(negedge clk);
        checks++;
        if ({boutq4, dq4, cnt4} !== {5'h07, 8'd1}) begin errors++; $display("FAIL w4_nb_q: got %h expected %h", {boutq4, dq4, cnt4}, {5'h07, 8'd1}); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        a2 = 1'b0; b2 = 1'b1; bin2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (cnt2 !== exp_seq[i]) begin errors++; $display("FAIL sat_%0d: got %0d expected %0d", i, cnt2, exp_seq[i]); end
        end
        b2 = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h5; bin4 = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dq4, boutq4} !== 5'h00) begin errors++; $display("FAIL ar_q4: got %h expected %h", {dq4, boutq4}, 5'h00); end
        checks++;
        if (cnt4 !== 8'd0) begin errors++; $display("FAIL ar_cnt4: got %0d expected %0d", cnt4, 0); end
        checks++;
        if (cnt2 !== 2'd0) begin errors++; $display("FAIL ar_cnt2: got %0d expected %0d", cnt2, 0); end
        checks++;
        if ({bout4, d4} !== 5'h1D) begin errors++; $display("FAIL ar_comb_hold: got %h expected %h", {bout4, d4}, 5'h1D); end
        a4 = 4'h9; b4 = 4'h2; bin4 = 1'b0;
        #1;
        checks++;
        if ({bout4, d4} !== 5'h07) begin errors++; $display("FAIL ar_comb_track: got %h expected %h", {bout4, d4}, 5'h07); end
        @(negedge clk);
        checks++;
        if ({dq4, boutq4, cnt4} !== 13'h0) begin errors++; $display("FAIL ar_hold: got %h expected %h", {dq4, boutq4, cnt4}, 13'h0); end
        a4 = 4'h0; b4 = 4'h1; bin4 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({boutq4, dq4} !== 5'h1F) begin errors++; $display("FAIL ar_first_cap: got %h expected %h", {boutq4, dq4}, 5'h1F); end
        checks++;
        if (cnt4 !== 8'd1) begin errors++; $display("FAIL ar_first_cnt: got %0d expected %0d", cnt4, 1); end
    endtask

`ifdef FS_OVF_EN
    task automatic test_overflow();
        @(negedge clk);
        a4 = 4'h8; b4 = 4'h1; bin4 = 1'b0;
        #1;
        checks++;
        if (d4 !== 4'h7) begin errors++; $display("FAIL ovf_d: got %h expected %h", d4, 4'h7); end
        @(negedge clk);
        checks++;
        if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected %b", ovf4, 1'b1); end
        a4 = 4'h3; b4 = 4'h1;
        @(negedge clk);
        checks++;
        if (ovf4 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected %b", ovf4, 1'b0); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
        a2 = 1'b0; b2 = 1'b0; bin2 = 1'b0;
        test_reset();
        test_sweep();
        test_no_borrow();
        test_width4();
        test_saturate();
        test_async_reset();
`ifdef FS_OVF_EN
        test_overflow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
